z_scheduler: RTL and testbench

Z_SCHEDULER -- requirements
Module: z_scheduler

---
 rtl/z_scheduler.sv | 173 +++++++++++++++++
 tb/tb_z_scheduler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/z_scheduler.sv
// Z-row drain scheduler: turns engine row-ready events into a stream of
// chunk-sized write requests walking base + row*stride + iter*CHUNK_BYTES.
module z_scheduler #(
    parameter int unsigned BW         = 256,
    parameter int unsigned ELEM_BYTES = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic [79:0] params_i,
    input  logic        row_valid_i,
    output logic        row_ready_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_addr_o,
    output logic        req_last_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam int unsigned CHUNK_BYTES = BW / 8;
    localparam int unsigned AW          = 32;
    localparam int unsigned CW          = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ROW = 2'd1,
        ISSUE    = 2'd2,
        DONE     = 2'd3
    } state_e;

    // Parameter fields, MSB first: base, y_columns, y_row_iters, x_rows
    logic [AW-1:0] p_base;
    logic [CW-1:0] p_ycols;
    logic [CW-1:0] p_iters;
    logic [CW-1:0] p_rows;

    assign p_base  = params_i[79:48];
    assign p_ycols = params_i[47:32];
    assign p_iters = params_i[31:16];
    assign p_rows  = params_i[15:0];

    state_e        state_q, state_d;
    logic [CW-1:0] iter_q, iter_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] iters_m1_q, iters_m1_d;
    logic [CW-1:0] rows_m1_q, rows_m1_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic [AW-1:0] stride_q, stride_d;
    logic          row_ready_q, row_ready_d;
    logic          req_valid_q, req_valid_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // State and datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            row_q       <= '0;
            iters_m1_q  <= '0;
            rows_m1_q   <= '0;
            addr_q      <= '0;
            row_base_q  <= '0;
            stride_q    <= '0;
            row_ready_q <= 1'b0;
            req_valid_q <= 1'b0;
            last_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            row_q       <= row_d;
            iters_m1_q  <= iters_m1_d;
            rows_m1_q   <= rows_m1_d;
            addr_q      <= addr_d;
            row_base_q  <= row_base_d;
            stride_q    <= stride_d;
            row_ready_q <= row_ready_d;
            req_valid_q <= req_valid_d;
            last_q      <= last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state, counters and running-address update
    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        row_d      = row_q;
        iters_m1_d = iters_m1_q;
        rows_m1_d  = rows_m1_q;
        addr_d     = addr_q;
        row_base_d = row_base_q;
        stride_d   = stride_q;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    stride_d   = AW'(32'(p_ycols) * 32'(ELEM_BYTES));
                    iters_m1_d = p_iters - CW'(1);
                    rows_m1_d  = p_rows - CW'(1);
                    row_base_d = p_base;
                    addr_d     = p_base;
                    iter_d     = '0;
                    row_d      = '0;
                    state_d    = (p_rows == '0 || p_iters == '0) ? DONE : WAIT_ROW;
                end
            end
            WAIT_ROW: begin
                if (row_valid_i && row_ready_q) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (req_valid_q && req_ready_i) begin
                    if (iter_q != iters_m1_q) begin
                        iter_d = iter_q + CW'(1);
                        addr_d = addr_q + AW'(CHUNK_BYTES);
                    end else if (row_q != rows_m1_q) begin
                        row_d      = row_q + CW'(1);
                        row_base_d = row_base_q + stride_q;
                        addr_d     = row_base_q + stride_q;
                        iter_d     = '0;
                        state_d    = WAIT_ROW;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Soft clear overrides everything, including a same-cycle handshake
        if (clear_i) begin
            state_d    = IDLE;
            iter_d     = '0;
            row_d      = '0;
            iters_m1_d = '0;
            rows_m1_d  = '0;
            addr_d     = '0;
            row_base_d = '0;
            stride_d   = '0;
        end
    end

    // Outputs are decoded from next state so they come straight off flops
    always_comb begin
        row_ready_d = (state_d == WAIT_ROW);
        req_valid_d = (state_d == ISSUE);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        last_d      = (state_d == ISSUE) && (iter_d == iters_m1_d) && (row_d == rows_m1_d);
    end

    assign row_ready_o = row_ready_q;
    assign req_valid_o = req_valid_q;
    assign req_addr_o  = addr_q;
    assign req_last_o  = last_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_z_scheduler.sv
// Scoreboard bench for z_scheduler: expected chunk addresses are queued per job
// from a direct base + row*stride + iter*chunk model and popped on each handshake.
module tb_z_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [79:0] params_i = '0;
    logic        row_valid_i = 1'b1;
    logic        row_ready_o;
    logic        req_valid_o;
    logic        req_ready_i = 1'b1;
    logic [31:0] req_addr_o;
    logic        req_last_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_err = 0;
    int done_seen = 0;
    int busy_seen = 0;
    int rr_seen = 0;
    int rv_seen = 0;

    logic [32:0] sb[$];

    z_scheduler #(.BW(256), .ELEM_BYTES(4)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .params_i   (params_i),
        .row_valid_i(row_valid_i),
        .row_ready_o(row_ready_o),
        .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i),
        .req_addr_o (req_addr_o),
        .req_last_o (req_last_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Reference address sequence; last flag only on the final chunk
    task automatic push_job(input logic [31:0] base, input logic [15:0] ycol,
                            input logic [15:0] iters, input logic [15:0] rows);
        logic [31:0] a;
        for (int r = 0; r < int'(rows); r++) begin
            for (int i = 0; i < int'(iters); i++) begin
                a = base + 32'(r) * 32'(ycol) * 32'd4 + 32'(i) * 32'd32;
                sb.push_back({(r == int'(rows) - 1) && (i == int'(iters) - 1), a});
            end
        end
    endtask

    // Handshake monitor, sampled on the falling edge
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (req_valid_o && req_ready_i && !clear_i) begin
                if (sb.size() == 0) begin
                    check("req_unexpected", 64'(sb.size()), 64'd1);
                end else begin
                    logic [32:0] e;
                    e = sb.pop_front();
                    check("req_addr", 64'(req_addr_o), 64'(e[31:0]));
                    check("req_last", 64'(req_last_o), 64'(e[32]));
                end
            end
            if (row_ready_o && req_valid_o) check("rdy_vld_excl", 64'(row_ready_o), 64'd0);
            if (done_o) done_seen++;
            if (busy_o) busy_seen++;
            if (row_ready_o) rr_seen++;
            if (req_valid_o) rv_seen++;
        end
    end

    task automatic run_job(input logic [31:0] base, input logic [15:0] ycol,
                           input logic [15:0] iters, input logic [15:0] rows,
                           input bit illegal, input bit bp, input bit rnd);
        int d0, b0, rr0, rv0, n;
        bit degen;
        degen = (rows == 0) || (iters == 0);
        d0 = done_seen; b0 = busy_seen; rr0 = rr_seen; rv0 = rv_seen;
        push_job(base, ycol, iters, rows);
        params_i = {base, ycol, iters, rows};
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        params_i = {$urandom, $urandom, 16'($urandom)};
        check("busy_after_start", 64'(busy_o), 64'd1);
        if (degen) check("degen_done_next", 64'(done_o), 64'd1);
        if (illegal) begin
            tick();
            tick();
            params_i = {32'h5555_0000, 16'd3, 16'd7, 16'd9};
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
        if (bp) begin
            n = 0;
            while (!(req_valid_o && req_addr_o == 32'h1020) && n < 50) begin
                tick();
                n++;
            end
            if (n >= 50) check("bp_wait_timeout", 64'(n), 64'd0);
            req_ready_i = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                check("bp_valid_hold", 64'(req_valid_o), 64'd1);
                check("bp_addr_hold", 64'(req_addr_o), 64'h1020);
            end
            req_ready_i = 1'b1;
        end
        n = 0;
        while (!done_o && n < 500) begin
            if (rnd) begin
                req_ready_i = 1'($urandom_range(0, 1));
                row_valid_i = 1'($urandom_range(0, 1));
            end
            tick();
            n++;
        end
        req_ready_i = 1'b1;
        row_valid_i = 1'b1;
        if (n >= 500) check("done_timeout", 64'(n), 64'd0);
        tick();
        check("done_pulses", 64'(done_seen - d0), 64'd1);
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("idle_after_done", 64'({busy_o, done_o}), 64'd0);
        if (degen) begin
            check("degen_busy_cycles", 64'(busy_seen - b0), 64'd1);
            check("degen_no_row_ready", 64'(rr_seen - rr0), 64'd0);
            check("degen_no_req", 64'(rv_seen - rv0), 64'd0);
        end
    endtask

    initial begin
        int n, d0;
        repeat (3) tick();
        check("rst_outputs", 64'({row_ready_o, req_valid_o, req_addr_o, req_last_o, busy_o, done_o}), 64'd0);
        rst_ni = 1'b1;

        // Nominal job, started right after reset release
        run_job(32'h1000, 16'd16, 16'd2, 16'd3, 1'b0, 1'b0, 1'b0);
        // Backpressure on the second request
        run_job(32'h1000, 16'd16, 16'd2, 16'd3, 1'b0, 1'b1, 1'b0);
        // Degenerate jobs
        run_job(32'h4000, 16'd16, 16'd2, 16'd0, 1'b0, 1'b0, 1'b0);
        run_job(32'h4000, 16'd16, 16'd0, 16'd5, 1'b0, 1'b0, 1'b0);
        // Address wrap across 2^32
        run_job(32'hFFFF_FFE0, 16'd8, 16'd2, 16'd1, 1'b0, 1'b0, 1'b0);
        // Start while busy must be ignored
        run_job(32'h0800, 16'd10, 16'd3, 16'd2, 1'b1, 1'b0, 1'b0);
        // Random handshake timing, odd stride
        run_job(32'h0012_3400, 16'd5, 16'd3, 16'd4, 1'b0, 1'b0, 1'b1);

        // Abort during ISSUE of row 1: only row 0 chunks may be handed off
        d0 = done_seen;
        sb.push_back({1'b0, 32'h2000});
        sb.push_back({1'b0, 32'h2020});
        params_i = {32'h2000, 16'd16, 16'd2, 16'd3};
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        n = 0;
        while (!(req_valid_o && req_addr_o == 32'h2040) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("abort_wait_timeout", 64'(n), 64'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check("abort_idle", 64'({busy_o, req_valid_o, row_ready_o}), 64'd0);
        check("abort_addr_cleared", 64'(req_addr_o), 64'd0);
        tick();
        check("abort_no_done", 64'(done_seen - d0), 64'd0);
        check("abort_sb", 64'(sb.size()), 64'd0);
        run_job(32'h3000, 16'd16, 16'd2, 16'd2, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
